// File: rtl/mby_msh_ingr_buf.sv
// Mesh ingress chunk buffer: credit-governed circular FIFO feeding the node
// data path, with registered credit return and sticky overflow flag.
module mby_msh_ingr_buf #(
    parameter int CHUNK_W = 512,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = $clog2(DEPTH+1)
) (
    input  logic               mclk,
    input  logic               i_reset_n,
    input  logic               i_chunk_vld,
    input  logic [CHUNK_W-1:0] i_chunk,
    output logic               o_crd_rtn,
    output logic               o_chunk_vld,
    output logic [CHUNK_W-1:0] o_chunk,
    input  logic               i_chunk_rdy,
    output logic [CNT_W-1:0]   o_occupancy,
    output logic               o_overflow,
    input  logic               i_clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CHUNK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               drop;

    assign pop  = (count != '0) && i_chunk_rdy;
    assign push = i_chunk_vld && ((count < FULL) || pop);
    assign drop = i_chunk_vld && !push;

    assign o_chunk_vld = (count != '0);
    assign o_chunk     = mem[rd_ptr];
    assign o_occupancy = count;

    // Storage is deliberately left out of reset.
    always_ff @(posedge mclk) begin
        if (push) begin
            mem[wr_ptr] <= i_chunk;
        end
    end

    always_ff @(posedge mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else begin
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
        end
    end

    // Set beats clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_crd_rtn  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_crd_rtn <= pop;
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule
